// File: rtl/cache_pkg.sv
// Shared sizes, FSM state type and requester IDs for the cache refill arbiter.
package cache_pkg;
    localparam int ADDR_LEN   = 25;
    localparam int DATA_LEN   = 32;
    localparam int OFFSET_LEN = 7;
    localparam int BEATS      = 32;

    typedef enum logic [1:0] {IDLE, CMD, WBURST, RBURST} state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-granted pointer only moves when a burst finishes.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_id,
    output logic       gnt_id
);
    import cache_pkg::*;

    logic last_id;

    // Reset points at the I-cache so the D-cache wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_id <= REQ_I;
        end else if (update) begin
            last_id <= upd_id;
        end
    end

    always_comb begin
        gnt_id = ~last_id;
        case (req)
            2'b01:   gnt_id = REQ_I;
            2'b10:   gnt_id = REQ_D;
            default: gnt_id = ~last_id;
        endcase
    end
endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one line-granular memory port between the I-cache (refill) and D-cache (refill/writeback).
module cache_refill_arbiter #(
    parameter int ADDR_LEN   = cache_pkg::ADDR_LEN,
    parameter int DATA_LEN   = cache_pkg::DATA_LEN,
    parameter int OFFSET_LEN = cache_pkg::OFFSET_LEN,
    parameter int BEATS      = cache_pkg::BEATS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req_valid,
    input  logic [1:0]               req_we,
    input  logic [1:0][ADDR_LEN-1:0] req_addr,
    output logic [1:0]               req_ready,
    input  logic [DATA_LEN-1:0]      wb_data,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    output logic [1:0]               rsp_valid,
    output logic [DATA_LEN-1:0]      rsp_data,
    output logic                     rsp_last,
    output logic                     mem_cmd_valid,
    input  logic                     mem_cmd_ready,
    output logic [ADDR_LEN-1:0]      mem_cmd_addr,
    output logic                     mem_cmd_we,
    output logic [DATA_LEN-1:0]      mem_wdata,
    output logic                     mem_wdata_valid,
    input  logic                     mem_wdata_ready,
    input  logic [DATA_LEN-1:0]      mem_rdata,
    input  logic                     mem_rdata_valid
);
    import cache_pkg::*;

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_LEN-1:0] LINE_MASK = ~ADDR_LEN'((64'd1 << OFFSET_LEN) - 64'd1);

    state_t             state, state_next;
    logic               grant;
    logic               arb_id;
    logic [ADDR_LEN-1:0] cmd_addr;
    logic               cmd_we;
    logic [CNT_W-1:0]   beat_cnt;
    logic               beat_done;
    logic               last_beat;
    logic               burst_end;

    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
    assign burst_end = beat_done & last_beat;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .update (burst_end),
        .upd_id (grant),
        .gnt_id (arb_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant, line address and direction are captured once in IDLE and frozen for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant    <= REQ_I;
            cmd_addr <= '0;
            cmd_we   <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (state == IDLE && |req_valid) begin
                grant    <= arb_id;
                cmd_addr <= req_addr[arb_id] & LINE_MASK;
                cmd_we   <= req_we[arb_id] & (arb_id == REQ_D);
            end
            if (beat_done) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next      = state;
        beat_done       = 1'b0;
        req_ready       = '0;
        mem_cmd_valid   = 1'b0;
        mem_cmd_addr    = '0;
        mem_cmd_we      = 1'b0;
        mem_wdata       = '0;
        mem_wdata_valid = 1'b0;
        wb_ready        = 1'b0;
        rsp_valid       = '0;
        rsp_data        = '0;
        rsp_last        = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) state_next = CMD;
            end
            CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_addr  = cmd_addr;
                mem_cmd_we    = cmd_we;
                if (mem_cmd_ready) begin
                    req_ready[grant] = 1'b1;
                    state_next       = cmd_we ? WBURST : RBURST;
                end
            end
            WBURST: begin
                mem_wdata       = wb_data;
                mem_wdata_valid = wb_valid;
                wb_ready        = mem_wdata_ready;
                beat_done       = wb_valid & mem_wdata_ready;
            end
            RBURST: begin
                rsp_data         = mem_rdata;
                rsp_valid[grant] = mem_rdata_valid;
                rsp_last         = mem_rdata_valid & last_beat;
                beat_done        = mem_rdata_valid;
            end
            default: state_next = IDLE;
        endcase
        if (beat_done && last_beat) state_next = IDLE;
    end
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter: a vector table for reset/command handshakes,
// then hand-written refill, writeback, round-robin, mid-burst reset and drop-out sequences.
module tb_cache_refill_arbiter;
    localparam int AW = 25;
    localparam int DW = 32;
    localparam int NB = 32;
    localparam logic [2:0] CHK_NONE = 3'b000;
    localparam logic [2:0] CHK_CMD  = 3'b001;
    localparam logic [2:0] CHK_W    = 3'b010;
    localparam logic [2:0] CHK_R    = 3'b100;
    localparam logic [2:0] CHK_ALL  = 3'b111;

    typedef struct packed {
        logic          rst;
        logic [1:0]    req_valid;
        logic [1:0]    req_we;
        logic [AW-1:0] addr_i;
        logic [AW-1:0] addr_d;
        logic          cmd_ready;
        logic [DW-1:0] wb_data;
        logic          wb_valid;
        logic          wdata_ready;
        logic [DW-1:0] rdata;
        logic          rdata_valid;
    } in_t;

    typedef struct packed {
        logic [1:0]    req_ready;
        logic          cmd_valid;
        logic [AW-1:0] cmd_addr;
        logic          cmd_we;
        logic [DW-1:0] wdata;
        logic          wdata_valid;
        logic          wb_ready;
        logic [1:0]    rsp_valid;
        logic [DW-1:0] rsp_data;
        logic          rsp_last;
    } out_t;

    typedef struct {
        string      name;
        in_t        stim;
        out_t       exp;
        logic [2:0] chk;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req_valid;
    logic [1:0]          req_we;
    logic [1:0][AW-1:0]  req_addr;
    logic [1:0]          req_ready;
    logic [DW-1:0]       wb_data;
    logic                wb_valid;
    logic                wb_ready;
    logic [1:0]          rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic                rsp_last;
    logic                mem_cmd_valid;
    logic                mem_cmd_ready;
    logic [AW-1:0]       mem_cmd_addr;
    logic                mem_cmd_we;
    logic [DW-1:0]       mem_wdata;
    logic                mem_wdata_valid;
    logic                mem_wdata_ready;
    logic [DW-1:0]       mem_rdata;
    logic                mem_rdata_valid;

    int   n_vectors = 0;
    int   n_miscompares = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    cache_refill_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_ready       (req_ready),
        .wb_data         (wb_data),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_last        (rsp_last),
        .mem_cmd_valid   (mem_cmd_valid),
        .mem_cmd_ready   (mem_cmd_ready),
        .mem_cmd_addr    (mem_cmd_addr),
        .mem_cmd_we      (mem_cmd_we),
        .mem_wdata       (mem_wdata),
        .mem_wdata_valid (mem_wdata_valid),
        .mem_wdata_ready (mem_wdata_ready),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid)
    );

    task automatic applyStimulus(input in_t s);
        rst             = s.rst;
        req_valid       = s.req_valid;
        req_we          = s.req_we;
        req_addr[0]     = s.addr_i;
        req_addr[1]     = s.addr_d;
        mem_cmd_ready   = s.cmd_ready;
        wb_data         = s.wb_data;
        wb_valid        = s.wb_valid;
        mem_wdata_ready = s.wdata_ready;
        mem_rdata       = s.rdata;
        mem_rdata_valid = s.rdata_valid;
    endtask

    task automatic cmpField(input string tag, input string field,
                            input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s %s: got %h, want %h", tag, field, act, exp);
        end
    endtask

    // Handshakes are always checked; data/address buses only where their value is defined.
    task automatic checkOutput(input string tag, input out_t e, input logic [2:0] chk);
        cmpField(tag, "req_ready",       32'(req_ready),       32'(e.req_ready));
        cmpField(tag, "mem_cmd_valid",   32'(mem_cmd_valid),   32'(e.cmd_valid));
        cmpField(tag, "mem_wdata_valid", 32'(mem_wdata_valid), 32'(e.wdata_valid));
        cmpField(tag, "wb_ready",        32'(wb_ready),        32'(e.wb_ready));
        cmpField(tag, "rsp_valid",       32'(rsp_valid),       32'(e.rsp_valid));
        cmpField(tag, "rsp_last",        32'(rsp_last),        32'(e.rsp_last));
        if (chk[0]) begin
            cmpField(tag, "mem_cmd_addr", 32'(mem_cmd_addr), 32'(e.cmd_addr));
            cmpField(tag, "mem_cmd_we",   32'(mem_cmd_we),   32'(e.cmd_we));
        end
        if (chk[1]) cmpField(tag, "mem_wdata", mem_wdata, e.wdata);
        if (chk[2]) cmpField(tag, "rsp_data",  rsp_data,  e.rsp_data);
    endtask

    task automatic runCycle(input string tag, input in_t s, input out_t e, input logic [2:0] chk);
        applyStimulus(s);
        @(negedge clk);
        checkOutput(tag, e, chk);
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input string name, input in_t s, input out_t e, input logic [2:0] chk);
        vec_t v;
        v.name = name;
        v.stim = s;
        v.exp  = e;
        v.chk  = chk;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        in_t  s;
        out_t e;
        int   wb_beat;

        // Reset held with every input busy, then an I-cache refill command accepted after 3 wait cycles.
        s = '0;
        s.rst = 1'b1; s.req_valid = 2'b11; s.req_we = 2'b11; s.cmd_ready = 1'b1;
        s.wb_data = 32'h1234_5678; s.wb_valid = 1'b1; s.wdata_ready = 1'b1;
        s.rdata = 32'hDEAD_BEEF; s.rdata_valid = 1'b1;
        e = '0;
        addVec("reset_held", s, e, CHK_ALL);
        s.rst = 1'b0; s.req_valid = 2'b00;
        addVec("post_reset_idle", s, e, CHK_ALL);
        s.req_valid = 2'b01; s.req_we = 2'b01; s.addr_i = 25'h0012345; s.addr_d = 25'h1ABCDEF;
        s.cmd_ready = 1'b0; s.wb_valid = 1'b0; s.rdata_valid = 1'b0;
        addVec("i_request", s, e, CHK_NONE);
        s.req_valid = 2'b00; s.addr_i = 25'h1FFFFFF;
        e.cmd_valid = 1'b1; e.cmd_addr = 25'h0012300; e.cmd_we = 1'b0;
        addVec("cmd_wait1", s, e, CHK_CMD);
        addVec("cmd_wait2", s, e, CHK_CMD);
        addVec("cmd_wait3", s, e, CHK_CMD);
        s.cmd_ready = 1'b1; e.req_ready = 2'b01;
        addVec("cmd_accept", s, e, CHK_CMD);

        s = '0;
        s.rst = 1'b1;
        applyStimulus(s);
        @(posedge clk);
        @(posedge clk);
        #1;

        foreach (vecs[i]) runCycle(vecs[i].name, vecs[i].stim, vecs[i].exp, vecs[i].chk);

        // I-cache refill: 32 beats with an idle gap before every eighth beat, including while on beat 31.
        for (int b = 0; b < NB; b++) begin
            if (b % 8 == 7) begin
                s = '0; s.rdata = 32'hBAD0_0000 | 32'(b);
                e = '0; e.rsp_data = s.rdata;
                runCycle($sformatf("refill_gap%0d", b), s, e, CHK_R);
            end
            s = '0; s.rdata = 32'hA500_0000 | 32'(b); s.rdata_valid = 1'b1;
            e = '0; e.rsp_data = s.rdata; e.rsp_valid = 2'b01; e.rsp_last = (b == NB - 1);
            runCycle($sformatf("refill_beat%0d", b), s, e, CHK_R);
        end
        s = '0; s.rdata = 32'h5555_AAAA; s.rdata_valid = 1'b1; s.cmd_ready = 1'b1;
        e = '0;
        runCycle("refill_done_idle", s, e, CHK_NONE);

        // Simultaneous requests right after reset: D-cache writeback first, then the I-cache.
        s = '0; s.rst = 1'b1;
        runCycle("tie_reset", s, e, CHK_NONE);
        s = '0; s.req_valid = 2'b11; s.req_we = 2'b10;
        s.addr_i = 25'h0000080; s.addr_d = 25'h10000FF;
        s.wb_data = 32'hCAFE_0000; s.wb_valid = 1'b1; s.wdata_ready = 1'b1;
        s.rdata = 32'h0BAD_F00D; s.rdata_valid = 1'b1;
        runCycle("tie_request", s, e, CHK_ALL);
        s.cmd_ready = 1'b1; s.wb_valid = 1'b0; s.rdata_valid = 1'b0;
        e.cmd_valid = 1'b1; e.cmd_addr = 25'h1000080; e.cmd_we = 1'b1; e.req_ready = 2'b10;
        runCycle("d_cmd_accept", s, e, CHK_CMD);

        wb_beat = 0;
        for (int c = 0; c < 200 && wb_beat < NB; c++) begin
            s.cmd_ready   = 1'b0;
            s.wdata_ready = (c % 2 == 0);
            s.wb_valid    = (c % 5 != 4);
            s.wb_data     = 32'hD000_0000 | 32'(wb_beat);
            e = '0;
            e.wdata = s.wb_data; e.wdata_valid = s.wb_valid; e.wb_ready = s.wdata_ready;
            runCycle($sformatf("wb_cycle%0d_beat%0d", c, wb_beat), s, e, CHK_W);
            if (s.wb_valid && s.wdata_ready) wb_beat++;
        end
        cmpField("wb_beats_sent", "beats", 32'(wb_beat), 32'(NB));

        s.wb_valid = 1'b1; s.wdata_ready = 1'b1; s.wb_data = 32'hFFFF_0000;
        e = '0;
        runCycle("rr_idle_gap", s, e, CHK_NONE);
        s.req_valid = 2'b00; s.cmd_ready = 1'b1; s.wb_valid = 1'b0;
        e.cmd_valid = 1'b1; e.cmd_addr = 25'h0000080; e.cmd_we = 1'b0; e.req_ready = 2'b01;
        runCycle("i_cmd_after_d", s, e, CHK_CMD);

        // Reset lands on read beat 10 of the I-cache refill.
        for (int b = 0; b <= 10; b++) begin
            s = '0; s.rst = (b == 10); s.rdata = 32'hC100_0000 | 32'(b); s.rdata_valid = 1'b1;
            e = '0; e.rsp_data = s.rdata; e.rsp_valid = 2'b01;
            runCycle($sformatf("pre_reset_beat%0d", b), s, e, CHK_R);
        end
        for (int k = 0; k < 3; k++) begin
            s = '0; s.rdata = 32'hC100_0000 | 32'(11 + k); s.rdata_valid = 1'b1;
            s.cmd_ready = 1'b1; s.wb_valid = 1'b1; s.wdata_ready = 1'b1; s.wb_data = 32'h7777_0000;
            e = '0;
            runCycle($sformatf("after_reset%0d", k), s, e, (k == 0) ? CHK_ALL : CHK_NONE);
        end

        // D-cache refill while the I-cache request comes and goes; the grant must stay on D.
        s = '0; s.req_valid = 2'b10; s.addr_i = 25'h0000100; s.addr_d = 25'h0ABCDE0;
        e = '0;
        runCycle("d_request", s, e, CHK_NONE);
        s.req_valid = 2'b11;
        e.cmd_valid = 1'b1; e.cmd_addr = 25'h0ABCD80; e.cmd_we = 1'b0;
        runCycle("d_cmd_wait", s, e, CHK_CMD);
        s.cmd_ready = 1'b1; e.req_ready = 2'b10;
        runCycle("d_cmd_accept2", s, e, CHK_CMD);
        for (int b = 0; b < NB; b++) begin
            s = '0; s.req_valid = (b < 5) ? 2'b11 : 2'b00; s.addr_i = 25'h0000100;
            s.rdata = 32'hE200_0000 | 32'(b); s.rdata_valid = 1'b1;
            e = '0; e.rsp_data = s.rdata; e.rsp_valid = 2'b10; e.rsp_last = (b == NB - 1);
            runCycle($sformatf("d_refill_beat%0d", b), s, e, CHK_R);
        end
        for (int k = 0; k < 3; k++) begin
            s = '0; s.cmd_ready = 1'b1; s.rdata_valid = 1'b1; s.rdata = 32'h1111_2222;
            e = '0;
            runCycle($sformatf("no_stale_i_cmd%0d", k), s, e, CHK_NONE);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule

// File: doc/cache_refill_arbiter.md
CACHE_REFILL_ARBITER -- requirements
Module: cache_refill_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_LEN, default 25, byte-address width.
REQ-002 The block SHALL have parameter DATA_LEN, default 32, beat width in bits.
REQ-003 The block SHALL have parameter OFFSET_LEN, default 7, line-offset bits (128-byte line).
REQ-004 The block SHALL have parameter BEATS, default 32, beats per line (LINE_SIZE 1024 / DATA_LEN).
REQ-005 The block SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port req_valid, input, 2, line request per requester (bit 0 = I-cache, bit 1 = D-cache).
REQ-008 The block SHALL have port req_we, input, 2, 1 = writeback line, 0 = refill; bit 0 is ignored and treated as 0.
REQ-009 The block SHALL have port req_addr, input, 2 x ADDR_LEN, request byte address per requester.
REQ-010 The block SHALL have port req_ready, output, 2, one-cycle pulse when the request's command is accepted by memory.
REQ-011 The block SHALL have port wb_data, input, DATA_LEN, writeback beat from the D-cache.
REQ-012 The block SHALL have port wb_valid / wb_ready, input / output, 1 each, writeback beat handshake.
REQ-013 The block SHALL have port rsp_valid, output, 2, refill beat valid, one-hot to the granted requester.
REQ-014 The block SHALL have port rsp_data, output, DATA_LEN, refill beat, shared by both requesters.
REQ-015 The block SHALL have port rsp_last, output, 1, asserted with the final refill beat.
REQ-016 The block SHALL have port mem_cmd_valid / mem_cmd_ready, output / input, 1 each, memory command handshake.
REQ-017 The block SHALL have port mem_cmd_addr / mem_cmd_we, output, ADDR_LEN / 1, line-aligned address and direction.
REQ-018 The block SHALL have port mem_wdata / mem_wdata_valid / mem_wdata_ready, output / output / input, DATA_LEN / 1 / 1, write beat channel.
REQ-019 The block SHALL have port mem_rdata / mem_rdata_valid, input, DATA_LEN / 1, read beat channel, always accepted.

Function
REQ-020 The FSM SHALL have states IDLE, CMD, WBURST and RBURST.
REQ-021 In IDLE with any req_valid set, the block SHALL register a grant and go to CMD the next cycle.
REQ-022 With both requesters valid, the block SHALL grant the one not granted last (round-robin); with one valid, it SHALL grant that one.
REQ-023 In CMD, mem_cmd_valid SHALL be 1, with mem_cmd_addr = granted req_addr with its low OFFSET_LEN bits zeroed.
REQ-024 In CMD, mem_cmd_valid and mem_cmd_addr SHALL hold stable until mem_cmd_ready.
REQ-025 On mem_cmd_ready in CMD, req_ready[grant] SHALL pulse for exactly that cycle, and the FSM SHALL go to WBURST if mem_cmd_we else RBURST.
REQ-026 In WBURST, mem_wdata SHALL equal wb_data, mem_wdata_valid SHALL equal wb_valid, and wb_ready SHALL equal mem_wdata_ready, all combinational pass-through.
REQ-027 In RBURST, rsp_data SHALL equal mem_rdata and rsp_valid[grant] SHALL equal mem_rdata_valid, combinationally; the block SHALL apply no backpressure.
REQ-028 A log2(BEATS)-bit beat counter SHALL increment on each completed beat; rsp_last SHALL be 1 when counter = BEATS-1 and a read beat is valid.
REQ-029 After beat BEATS-1 completes, the counter SHALL wrap to 0 and the FSM SHALL return to IDLE the next cycle, and the last-granted pointer SHALL update.
REQ-030 Requests arriving or dropping mid-burst SHALL be ignored until IDLE; the grant SHALL not change mid-burst.
REQ-031 Outside CMD/WBURST/RBURST, all handshake outputs (mem_cmd_valid, mem_wdata_valid, wb_ready, rsp_valid, rsp_last, req_ready) SHALL be 0.
REQ-032 IDLE-to-CMD latency SHALL be 1 cycle; back-to-back requests SHALL cost exactly 1 IDLE cycle between bursts.

Reset
REQ-033 When rst=1 at a clock edge, the FSM SHALL go to IDLE, the counter SHALL clear to 0, and the last-granted pointer SHALL be set to I-cache (so the D-cache wins the first tie).
REQ-034 In the cycle after reset, all outputs SHALL be 0, including mem_cmd_addr, mem_cmd_we and rsp_data.
REQ-035 A reset mid-burst SHALL abandon the burst with no further beats, pulses or rsp_last.

Structure
REQ-036 Package cache_pkg SHALL hold ADDR_LEN, DATA_LEN, OFFSET_LEN, BEATS, the FSM state enum, and requester IDs REQ_I=0 and REQ_D=1.
REQ-037 The two-way round-robin grant logic SHALL be one sub-module, rr_arb2; all other logic SHALL be inline.

Verification
REQ-038 Bench SHALL cover: I-cache refill at addr 0x0012345, memory ready after 3 cycles -> mem_cmd_addr 0x0012300, one req_ready[0] pulse, 32 rsp_valid[0] beats, rsp_last on beat 31.
REQ-039 Bench SHALL cover: both requests in same cycle after reset -> D-cache granted first, I-cache granted after 1 IDLE cycle.
REQ-040 Bench SHALL cover: D-cache writeback, mem_wdata_ready low every other cycle -> 32 beats passed in order, wb_ready mirrors mem_wdata_ready, then IDLE.
REQ-041 Bench SHALL cover: rst asserted at read beat 10 -> next cycle IDLE, all outputs 0, no rsp_last; new request then serviced normally.
REQ-042 Bench SHALL cover: I-cache request deasserted mid D-cache burst -> no grant change, and no I-cache command issued after return to IDLE.
